// File: rtl/fp_class_pkg.sv
// Shared constants, FSM state type and parameter helpers for the FP
// classifier / normaliser.
package fp_class_pkg;

  localparam int CLS_W    = 6;
  localparam int CLS_SNAN = 5;
  localparam int CLS_QNAN = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_ZERO = 2;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } fp_state_e;

  function automatic int fp_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int fp_steps(input int man_w);
    return $clog2(man_w + 32'sd1);
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational field splitter and one-hot classifier; also produces the
// final exponent/significand for every class except subnormal.
module fp_class_decode
  import fp_class_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0]  f_i,
  output logic                  sign_o,
  output logic [CLS_W-1:0]      class_o,
  output logic signed [EXP_W+1:0] exp_o,
  output logic [MAN_W:0]        sig_o,
  output logic                  is_sub_o
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));

  logic [EXP_W-1:0] exp_f_s;
  logic [MAN_W-1:0] frac_s;
  logic             exp_ones_s;
  logic             exp_zero_s;
  logic             frac_zero_s;

  assign sign_o      = f_i[EXP_W+MAN_W];
  assign exp_f_s     = f_i[EXP_W+MAN_W-1 -: EXP_W];
  assign frac_s      = f_i[MAN_W-1:0];
  assign exp_ones_s  = &exp_f_s;
  assign exp_zero_s  = ~|exp_f_s;
  assign frac_zero_s = ~|frac_s;
  assign is_sub_o    = class_o[CLS_SUB];

  // One-hot class selection
  always_comb begin
    class_o = '0;
    if (exp_ones_s) begin
      if (frac_zero_s) begin
        class_o[CLS_INF] = 1'b1;
      end else if (frac_s[MAN_W-1]) begin
        class_o[CLS_QNAN] = 1'b1;
      end else begin
        class_o[CLS_SNAN] = 1'b1;
      end
    end else if (exp_zero_s) begin
      if (frac_zero_s) begin
        class_o[CLS_ZERO] = 1'b1;
      end else begin
        class_o[CLS_SUB] = 1'b1;
      end
    end else begin
      class_o[CLS_NORM] = 1'b1;
    end
  end

  // Normals get the bias removed and the hidden bit; everything else is raw
  always_comb begin
    exp_o = $signed({2'b00, exp_f_s});
    sig_o = {1'b0, frac_s};
    if (class_o[CLS_NORM]) begin
      exp_o = $signed({2'b00, exp_f_s}) - BIAS_X;
      sig_o = {1'b1, frac_s};
    end else begin
      exp_o = $signed({2'b00, exp_f_s});
      sig_o = {1'b0, frac_s};
    end
  end

endmodule

// File: rtl/fp_class_norm.sv
// Classifies an IEEE-754-style operand and normalises subnormals with a
// log-step shifter, one power-of-two step per NORM cycle.
module fp_class_norm
  import fp_class_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MAN_W:0]    in_f,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [EXP_W+1:0] out_exp,
  output logic [MAN_W:0]          out_sig,
  output logic [CLS_W-1:0]        out_class
);

  localparam int XW  = EXP_W + 2;
  localparam int SW  = MAN_W + 1;
  localparam int S   = fp_steps(MAN_W);
  localparam int STW = (S > 1) ? $clog2(S) : 1;
  localparam logic signed [XW-1:0] EMIN_X   = XW'(32'sd1 - fp_bias(EXP_W));
  localparam logic [STW-1:0]       STEP_TOP = STW'(S - 32'sd1);
  localparam logic [STW-1:0]       STEP_ONE = STW'(32'd1);

  fp_state_e state_q, state_d;

  logic                  dec_sign_s;
  logic [CLS_W-1:0]      dec_class_s;
  logic signed [XW-1:0]  dec_exp_s;
  logic [SW-1:0]         dec_sig_s;
  logic                  dec_is_sub_s;

  logic [SW-1:0]         work_sig_q, work_sig_d;
  logic [XW-1:0]         sa_q, sa_d;
  logic [STW-1:0]        step_q, step_d;
  logic                  work_sign_q, work_sign_d;

  logic                  sign_q, sign_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [SW-1:0]         sig_q, sig_d;
  logic [CLS_W-1:0]      class_q, class_d;

  logic [XW-1:0]         step_pow_s;
  logic [SW-1:0]         top_mask_s;
  logic                  top_zero_s;
  logic [SW-1:0]         shift_sig_s;
  logic [XW-1:0]         shift_sa_s;
  logic                  accept_s;

  fp_class_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_decode (
    .f_i      (in_f),
    .sign_o   (dec_sign_s),
    .class_o  (dec_class_s),
    .exp_o    (dec_exp_s),
    .sig_o    (dec_sig_s),
    .is_sub_o (dec_is_sub_s)
  );

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_sig   = sig_q;
  assign out_class = class_q;

  // Current normalisation step: shift by 2^step if the top 2^step bits are clear
  always_comb begin
    step_pow_s = {{(XW-1){1'b0}}, 1'b1} << step_q;
    top_mask_s = ~({SW{1'b1}} >> step_pow_s);
    top_zero_s = ((work_sig_q & top_mask_s) == '0);
    if (top_zero_s) begin
      shift_sig_s = work_sig_q << step_pow_s;
      shift_sa_s  = sa_q + step_pow_s;
    end else begin
      shift_sig_s = work_sig_q;
      shift_sa_s  = sa_q;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    work_sig_d  = work_sig_q;
    sa_d        = sa_q;
    step_d      = step_q;
    work_sign_d = work_sign_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    class_d     = class_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (dec_is_sub_s) begin
            state_d     = ST_NORM;
            work_sig_d  = dec_sig_s;
            sa_d        = '0;
            step_d      = STEP_TOP;
            work_sign_d = dec_sign_s;
          end else begin
            state_d = ST_DONE;
            sign_d  = dec_sign_s;
            exp_d   = dec_exp_s;
            sig_d   = dec_sig_s;
            class_d = dec_class_s;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_NORM: begin
        work_sig_d = shift_sig_s;
        sa_d       = shift_sa_s;
        if (step_q == '0) begin
          state_d          = ST_DONE;
          sign_d           = work_sign_q;
          exp_d            = EMIN_X - $signed(shift_sa_s);
          sig_d            = shift_sig_s;
          class_d          = '0;
          class_d[CLS_SUB] = 1'b1;
        end else begin
          step_d = step_q - STEP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_sig_q  <= '0;
      sa_q        <= '0;
      step_q      <= '0;
      work_sign_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      class_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_sig_q  <= work_sig_d;
      sa_q        <= sa_d;
      step_q      <= step_d;
      work_sign_q <= work_sign_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      class_q     <= class_d;
    end
  end

endmodule

// File: tb/tb_fp_class_norm.sv
// Scoreboard bench for fp_class_norm: half-precision instance for most
// scenarios, single-precision instance for the wide subnormal case.
module tb_fp_class_norm;

  typedef struct {
    logic              sign;
    logic signed [6:0] ex;
    logic [10:0]       sig;
    logic [5:0]        cls;
    int                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [15:0] in_f;
  logic in_ready, out_valid, out_sign;
  logic signed [6:0] out_exp;
  logic [10:0] out_sig;
  logic [5:0] out_class;

  logic b_in_valid;
  logic [31:0] b_in_f;
  logic b_in_ready, b_out_valid, b_out_sign;
  logic signed [9:0] b_out_exp;
  logic [23:0] b_out_sig;
  logic [5:0] b_out_class;

  int cyc = 0;
  int pass_cnt = 0;
  int chk_cnt = 0;
  exp_t sb[$];

  fp_class_norm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_sig(out_sig), .out_class(out_class)
  );

  fp_class_norm #(.EXP_W(8), .MAN_W(23)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_f(b_in_f),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_sign(b_out_sign),
    .out_exp(b_out_exp), .out_sig(b_out_sig), .out_class(b_out_class)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1);
  end

  // Reference: leading-one search instead of stepwise shifting
  function automatic exp_t model(input logic [15:0] f);
    exp_t e;
    logic [4:0] ef;
    logic [9:0] fr;
    int p;
    int sh;
    e.sign = f[15]; ef = f[14:10]; fr = f[9:0]; e.lat = 1;
    if (ef == 5'h1F) begin
      e.ex  = {2'b00, ef};
      e.sig = {1'b0, fr};
      e.cls = (fr == 10'd0) ? 6'b001000 : (fr[9] ? 6'b010000 : 6'b100000);
    end else if (ef == 5'd0 && fr == 10'd0) begin
      e.ex = 7'sd0; e.sig = 11'd0; e.cls = 6'b000100;
    end else if (ef == 5'd0) begin
      p = 0;
      for (int i = 0; i < 10; i++) if (fr[i]) p = i;
      sh = 10 - p;
      e.sig = {1'b0, fr} << sh;
      e.ex  = 7'(1 - 15 - sh);
      e.cls = 6'b000010;
      e.lat = 5;
    end else begin
      e.ex  = 7'(int'(ef) - 15);
      e.sig = {1'b1, fr};
      e.cls = 6'b000001;
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] f, output int acc_c, output bit ok);
    logic rdy;
    @(negedge clk);
    in_valid = 1'b1; in_f = f; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 rdy = in_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) begin ok = 1'b1; break; end
    end
    acc_c = cyc;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int acc_c, output exp_t r, output bit ok);
    ok = 1'b0; r.sign = 1'bx; r.ex = 'x; r.sig = 'x; r.cls = 'x; r.lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin
        r.sign = out_sign; r.ex = out_exp; r.sig = out_sig; r.cls = out_class;
        r.lat = cyc - acc_c + 1; ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input logic [15:0] f, input exp_t e, output exp_t got,
                         output exp_t want, output bit ok);
    int a;
    bit s_ok, c_ok;
    sb.push_back(e);
    send(f, a, s_ok);
    collect(a, got, c_ok);
    ok = s_ok & c_ok;
    want = sb.pop_front();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_f = 16'h0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_f = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({out_valid, out_sign, out_exp, out_sig, out_class} !== 26'd0)
      $display("FAIL reset_outputs: got v=%b s=%b e=%0d sig=%h cls=%b, expected all zero",
               out_valid, out_sign, out_exp, out_sig, out_class);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_table(input string name, input logic [15:0] vecs[], input exp_t exps[]);
    exp_t got, want;
    bit ok;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], exps[i], got, want, ok);
      chk_cnt++;
      if (!ok || {got.sign, got.ex, got.sig, got.cls} !== {want.sign, want.ex, want.sig, want.cls})
        $display("FAIL %s f=%h: got s=%b e=%0d sig=%h cls=%b, expected s=%b e=%0d sig=%h cls=%b",
                 name, vecs[i], got.sign, got.ex, got.sig, got.cls,
                 want.sign, want.ex, want.sig, want.cls);
      else pass_cnt++;
      chk_cnt++;
      if (got.lat != want.lat)
        $display("FAIL %s_latency f=%h: got %0d, expected %0d", name, vecs[i], got.lat, want.lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_normal();
    logic [15:0] v[] = '{16'h3C00, 16'hBC00, 16'h7BFF};
    exp_t e[] = new[3];
    e[0].sign = 1'b0; e[0].ex = 7'sd0;  e[0].sig = 11'h400; e[0].cls = 6'b000001; e[0].lat = 1;
    e[1].sign = 1'b1; e[1].ex = 7'sd0;  e[1].sig = 11'h400; e[1].cls = 6'b000001; e[1].lat = 1;
    e[2].sign = 1'b0; e[2].ex = 7'sd15; e[2].sig = 11'h7FF; e[2].cls = 6'b000001; e[2].lat = 1;
    test_table("normal", v, e);
  endtask

  task automatic test_subnormal();
    logic [15:0] v[] = '{16'h0001, 16'h0200, 16'h83FF};
    exp_t e[] = new[3];
    e[0].sign = 1'b0; e[0].ex = -7'sd24; e[0].sig = 11'h400; e[0].cls = 6'b000010; e[0].lat = 5;
    e[1].sign = 1'b0; e[1].ex = -7'sd15; e[1].sig = 11'h400; e[1].cls = 6'b000010; e[1].lat = 5;
    e[2].sign = 1'b1; e[2].ex = -7'sd15; e[2].sig = 11'h7FE; e[2].cls = 6'b000010; e[2].lat = 5;
    test_table("subnormal", v, e);
  endtask

  task automatic test_specials();
    logic [15:0] v[] = '{16'h7C00, 16'h7E00, 16'h7D00, 16'h8000};
    exp_t e[] = new[4];
    e[0].sign = 1'b0; e[0].ex = 7'sd31; e[0].sig = 11'h000; e[0].cls = 6'b001000; e[0].lat = 1;
    e[1].sign = 1'b0; e[1].ex = 7'sd31; e[1].sig = 11'h200; e[1].cls = 6'b010000; e[1].lat = 1;
    e[2].sign = 1'b0; e[2].ex = 7'sd31; e[2].sig = 11'h100; e[2].cls = 6'b100000; e[2].lat = 1;
    e[3].sign = 1'b1; e[3].ex = 7'sd0;  e[3].sig = 11'h000; e[3].cls = 6'b000100; e[3].lat = 1;
    test_table("special", v, e);
  endtask

  task automatic test_random();
    logic [15:0] v[] = new[16];
    exp_t e[] = new[16];
    for (int i = 0; i < 16; i++) begin
      v[i] = 16'($urandom);
      if (i % 2 == 0) v[i][14:10] = 5'd0;
      e[i] = model(v[i]);
    end
    test_table("random", v, e);
  endtask

  task automatic test_backpressure();
    exp_t got, got2, want, snap;
    bit ok, ok2, sok;
    int a;
    out_ready = 1'b0;
    sb.push_back(model(16'h3C00));
    send(16'h3C00, a, sok);
    collect(a, got, ok);
    snap = got;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_sign, out_exp, out_sig, out_class} !== {snap.sign, snap.ex, snap.sig, snap.cls})
        $display("FAIL hold_cycle%0d: got v=%b rdy=%b e=%0d sig=%h cls=%b, expected v=1 rdy=0 e=%0d sig=%h cls=%b",
                 i, out_valid, in_ready, out_exp, out_sig, out_class, snap.ex, snap.sig, snap.cls);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b1; in_f = 16'h0001; out_ready = 1'b1;
    sb.push_back(model(16'h0001));
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL release_ready: got %b, expected 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    a = cyc; in_valid = 1'b0;
    want = sb.pop_front();
    chk_cnt++;
    if (!ok || !sok || {got.sign, got.ex, got.sig, got.cls} !== {want.sign, want.ex, want.sig, want.cls})
      $display("FAIL held_result: got e=%0d sig=%h cls=%b, expected e=%0d sig=%h cls=%b",
               got.ex, got.sig, got.cls, want.ex, want.sig, want.cls);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL no_bubble_accept: got out_valid=%b, expected 0 (in NORM)", out_valid);
    else pass_cnt++;
    collect(a, got2, ok2);
    want = sb.pop_front();
    chk_cnt++;
    if (!ok2 || {got2.ex, got2.sig, got2.cls, got2.lat} !== {want.ex, want.sig, want.cls, want.lat})
      $display("FAIL bp_second: got e=%0d sig=%h cls=%b lat=%0d, expected e=%0d sig=%h cls=%b lat=%0d",
               got2.ex, got2.sig, got2.cls, got2.lat, want.ex, want.sig, want.cls, want.lat);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[] = '{16'h3C00, 16'h4000, 16'hC200, 16'h7C00};
    exp_t want;
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_f = v[i];
      sb.push_back(model(v[i]));
      #1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b, expected 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      want = sb.pop_front();
      chk_cnt++;
      if (out_valid !== 1'b1 ||
          {out_sign, out_exp, out_sig, out_class} !== {want.sign, want.ex, want.sig, want.cls})
        $display("FAIL b2b_out%0d: got v=%b s=%b e=%0d sig=%h cls=%b, expected v=1 s=%b e=%0d sig=%h cls=%b",
                 i, out_valid, out_sign, out_exp, out_sig, out_class, want.sign, want.ex, want.sig, want.cls);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_norm();
    int a;
    bit ok;
    bit seen;
    send(16'h0001, a, ok);
    @(negedge clk); @(posedge clk);
    @(negedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 6'd0)
      $display("FAIL norm_reset_release: got rdy=%b v=%b cls=%b, expected rdy=1 v=0 cls=000000",
               in_ready, out_valid, out_class);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (seen) $display("FAIL norm_reset_discard: got out_valid=1 after reset, expected 0");
    else pass_cnt++;
  endtask

  task automatic test_wide();
    logic [31:0] v[2] = '{32'h0000_0001, 32'h3F80_0000};
    logic signed [9:0] ex[2] = '{-10'sd149, 10'sd0};
    logic [5:0] cl[2] = '{6'b000010, 6'b000001};
    int lat[2] = '{6, 1};
    int a, l;
    logic rdy;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_f = v[k]; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1 rdy = b_in_ready;
        @(posedge clk); #1;
        if (rdy === 1'b1) break;
      end
      a = cyc; b_in_valid = 1'b0; l = -1;
      for (int i = 0; i < 40; i++) begin
        if (b_out_valid === 1'b1) begin l = cyc - a + 1; ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk_cnt++;
      if (!ok || b_out_exp !== ex[k] || b_out_sig !== 24'h800000 || b_out_class !== cl[k] || l != lat[k])
        $display("FAIL wide%0d: got e=%0d sig=%h cls=%b lat=%0d, expected e=%0d sig=800000 cls=%b lat=%0d",
                 k, b_out_exp, b_out_sig, b_out_class, l, ex[k], cl[k], lat[k]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_specials();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_in_norm();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fp_class_norm.md
FP_CLASS_NORM -- requirements
Module: fp_class_norm

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width; legal range 3..11.
REQ-002 Parameter MAN_W, default 10, stored fraction width; MAN_W SHALL be <= 2^(EXP_W-1).
REQ-003 Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; S = clog2(MAN_W+1), the number of normalisation steps.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_f holds an operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_f  input  W  IEEE-754-style operand {sign, exp, frac}.
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_sign  output  1  operand sign.
REQ-012 out_exp  output  EXP_W+2 signed  unbiased exponent.
REQ-013 out_sig  output  MAN_W+1  significand with explicit leading bit.
REQ-014 out_class  output  6  one-hot class: [5] sNaN, [4] qNaN, [3] inf, [2] zero, [1] subnormal, [0] normal.

Function
REQ-015 Handshakes: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-016 FSM states: IDLE, NORM, DONE.
REQ-017 in_ready is 1 in IDLE, and in DONE when out_ready=1; it is 0 in NORM.
REQ-018 Classes: exp all-ones & frac!=0 & frac MSB=0 -> sNaN; exp all-ones & frac MSB=1 -> qNaN; exp all-ones & frac=0 -> inf; exp=0 & frac=0 -> zero; exp=0 & frac!=0 -> subnormal; otherwise normal.
REQ-019 Normal operands: out_exp = exp-BIAS; out_sig = {1, frac}.
REQ-020 Specials and zero: out_exp = raw exp field zero-extended; out_sig = {0, frac}.
REQ-021 Subnormal operands: sig starts as {0, frac} and shift count sa as 0. One NORM cycle is spent per step k = S-1 down to 0. If the top 2^k bits of sig are zero, sig shifts left by 2^k and sa increases by 2^k. Afterwards, out_exp = 1-BIAS-sa.
REQ-022 Latency from the accept edge to out_valid: 1 cycle for non-subnormal operands (IDLE->DONE); S+1 cycles for subnormal operands (IDLE->NORM for S cycles, then DONE).
REQ-023 DONE holds all outputs stable while out_ready=0.
REQ-024 In DONE with out_ready=1: if in_valid=1, the new operand is accepted in the same cycle with no bubble; otherwise the FSM returns to IDLE.
REQ-025 out_valid = (state==DONE); outputs are don't-care but stable while out_valid=0.
REQ-026 out_class is exactly one-hot whenever out_valid=1.

Reset
REQ-027 When rst_n=0 at a clock edge, the FSM goes to IDLE, out_valid=0, out_sign=0, out_exp=0, out_sig=0, out_class=0, and the step counter and sa are cleared.
REQ-028 Reset asserted in NORM or DONE discards the in-flight operand; no output transfer occurs for it.
REQ-029 in_ready is 1 on the first edge after rst_n returns to 1.

Structure
REQ-030 Package fp_class_pkg SHALL hold the class bit index constants, the FSM state typedef, and the bias/step-count helper functions.
REQ-031 Sub-module fp_class_decode SHALL be the purely combinational class and field decoder, instantiated once.

Verification
REQ-032 (EXP_W=5, MAN_W=10) in_f=0x3C00 -> out_exp=0, out_sig=0x400, class=normal, out_valid 1 cycle after accept.
REQ-033 in_f=0x0001 -> out_exp=-24, out_sig=0x400, class=subnormal, out_valid 5 cycles after accept; in_f=0x0200 -> out_exp=-15, out_sig=0x400.
REQ-034 in_f=0x7C00 / 0x7E00 / 0x7D00 / 0x8000 -> class inf / qNaN / sNaN / zero; out_exp=31, 31, 31, 0; out_sig=0x000, 0x200, 0x100, 0x000; out_sign=1 for 0x8000.
REQ-035 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> the next operand is accepted in the same cycle.
REQ-036 rst_n pulsed low during the 3rd NORM cycle -> out_valid stays 0 and in_ready=1 on the first edge after release.
REQ-037 (EXP_W=8, MAN_W=23) in_f=0x00000001 -> out_exp=-149, out_sig=0x800000, out_valid 6 cycles after accept.
